alu_ctrl_pipe: RTL and testbench
================================

ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  in  1  decoded instruction present this cycle.
REQ-004 SHALL have ports: main_op  in  2  main-control class: 00 load/store, 01 branch, 10 R-type, 11 reserved.
REQ-005 SHALL have ports: funct3  in  3  instruction funct3.
REQ-006 SHALL have ports: funct7_b30  in  1  instruction bit 30.
REQ-007 SHALL have ports: stall  in  1  hold stage register.
REQ-008 SHALL have ports: flush  in  1  kill stage register contents.
REQ-009 SHALL have ports: zero  in  1  ALU flag, 1 when ALU Result == 0.
REQ-010 SHALL have ports: Less  in  1  ALU flag, ALU Result[63].
REQ-011 SHALL have ports: ALUOp  out  4  registered ALU operation code.
REQ-012 SHALL have ports: out_valid  out  1  ALUOp is live.
REQ-013 SHALL have ports: illegal  out  1  registered, current op is undecodable.
REQ-014 SHALL have ports: br_valid  out  1  registered, branch resolved last cycle.
REQ-015 SHALL have ports: br_taken  out  1  registered, branch outcome.
REQ-016 SHALL have ports: taken_cnt  out  16  saturating count of taken branches.

Function
REQ-017 SHALL decode ALUOp codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB; no other code is ever driven.
REQ-018 SHALL map main_op 00 to ALUOp 0010.
REQ-019 SHALL map main_op 01 to ALUOp 0110.
REQ-020 SHALL map main_op 10 as: funct3 000 with funct7_b30=0 to 0010; funct3 000 with funct7_b30=1 to 0110; funct3 111 to 0000; funct3 110 to 0001.
REQ-021 SHALL treat all other main_op 10 combinations, and any main_op 11, as illegal: ALUOp=0010, illegal=1, no branch resolution.
REQ-022 SHALL treat main_op 01 with funct3 in {010, 011, 110, 111} as illegal.
REQ-023 SHALL implement a stage register holding ALUOp, illegal, out_valid, branch flag and funct3, loaded at a rising edge when stall=0 and flush=0; out_valid takes in_valid at that load.
REQ-024 SHALL give a latency of 1 cycle from input to ALUOp/out_valid.
REQ-025 SHALL keep the stage register unchanged while stall=1 and flush=0.
REQ-026 SHALL clear out_valid, illegal and the branch flag at the next edge when flush=1, regardless of stall; ALUOp becomes 0010.
REQ-027 SHALL resolve a legal branch at the clock edge that ends the cycle in which the stage register holds it with out_valid=1, stall=0 and flush=0, sampling zero/Less during that cycle.
REQ-028 SHALL compute br_taken by funct3: 000 BEQ = zero; 001 BNE = !zero; 100 BLT = Less; 101 BGE = !Less.
REQ-029 SHALL pulse br_valid for exactly one cycle per resolved branch, with br_taken valid only while br_valid=1; otherwise br_taken=0.
REQ-030 SHALL NOT resolve a branch held under stall more than once, even if it is held for multiple cycles.
REQ-031 SHALL NOT resolve a branch that is flushed in the same cycle it would resolve.
REQ-032 SHALL increment taken_cnt on each br_taken=1 pulse and saturate at 16'hFFFF with no wrap.
REQ-033 SHALL NOT let illegal suppress pipeline flow; out_valid still follows in_valid.

Reset
REQ-034 SHALL apply, on a reset=1 edge: ALUOp=0010, out_valid=0, illegal=0, br_valid=0, br_taken=0, taken_cnt=0.
REQ-035 SHALL give reset priority over stall and flush.
REQ-036 SHALL make a branch pending at reset never resolve.
REQ-037 SHALL have no asynchronous paths.

Verification
REQ-038 SHALL cover R-type decode: main_op=10, funct3=000, b30=1, in_valid=1 -> next cycle ALUOp=0110, out_valid=1, illegal=0; funct3=111 -> 0000; funct3=110 -> 0001.
REQ-039 SHALL cover BEQ resolution: main_op=01, funct3=000, then zero=1 during the held cycle -> one cycle later br_valid=1, br_taken=1, taken_cnt=1.
REQ-040 SHALL cover BLT under stall: stall=1 for 3 cycles with Less=1 and no resolution, then stall=0 -> exactly one br_valid pulse, br_taken=1.
REQ-041 SHALL cover flush with stall: main_op=10 loaded, then flush=1 and stall=1 together -> next cycle out_valid=0, ALUOp=0010, no br_valid.
REQ-042 SHALL cover illegal ops: main_op=11 -> illegal=1, ALUOp=0010; main_op=01 with funct3=010 -> illegal=1, br_valid stays 0.
REQ-043 SHALL cover saturation and reset: preload 65535 taken branches plus 1 more -> taken_cnt=FFFF; then reset=1 with a branch held -> all outputs at reset values, no br_valid.

Source files
------------

// File: rtl/alu_ctrl_pipe.sv
// ALU control decode with a one-deep stage register, branch resolution and a
// saturating taken-branch counter. The stage register supports stall (hold) and
// flush (kill). A branch resolves once, when it leaves the stage.
module alu_ctrl_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  main_op,
  input  logic [2:0]  funct3,
  input  logic        funct7_b30,
  input  logic        stall,
  input  logic        flush,
  input  logic        zero,
  input  logic        Less,
  output logic [3:0]  ALUOp,
  output logic        out_valid,
  output logic        illegal,
  output logic        br_valid,
  output logic        br_taken,
  output logic [15:0] taken_cnt
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // Stage register contents
  logic [3:0]  op_reg;
  logic        illegal_reg;
  logic        valid_reg;
  logic        branch_reg;
  logic [2:0]  funct3_reg;

  // Branch result and counter registers
  logic        br_valid_reg;
  logic        br_taken_reg;
  logic [15:0] taken_cnt_reg;

  // Combinational decode results
  logic [3:0]  dec_op;
  logic        dec_illegal;
  logic        dec_branch;
  logic        resolve;
  logic        cond_taken;

  // Decode the incoming instruction class into an ALU op, illegal and branch flags
  always_comb begin
    dec_op      = ALU_ADD;
    dec_illegal = 1'b0;
    dec_branch  = 1'b0;
    unique case (main_op)
      2'b00: dec_op = ALU_ADD;
      2'b01: begin
        if (funct3 == 3'b000 || funct3 == 3'b001 ||
            funct3 == 3'b100 || funct3 == 3'b101) begin
          dec_op     = ALU_SUB;
          dec_branch = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      2'b10: begin
        unique case (funct3)
          3'b000:  dec_op = funct7_b30 ? ALU_SUB : ALU_ADD;
          3'b111:  dec_op = ALU_AND;
          3'b110:  dec_op = ALU_OR;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Branch condition from the held funct3 and the current ALU flags
  always_comb begin
    cond_taken = 1'b0;
    unique case (funct3_reg)
      3'b000:  cond_taken = zero;
      3'b001:  cond_taken = ~zero;
      3'b100:  cond_taken = Less;
      3'b101:  cond_taken = ~Less;
      default: cond_taken = 1'b0;
    endcase
  end

  // A held branch resolves only on the edge where it leaves the stage unkilled
  assign resolve = valid_reg & branch_reg & ~stall & ~flush;

  // Stage register, branch result pulse and saturating counter
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg        <= ALU_ADD;
      illegal_reg   <= 1'b0;
      valid_reg     <= 1'b0;
      branch_reg    <= 1'b0;
      funct3_reg    <= 3'b000;
      br_valid_reg  <= 1'b0;
      br_taken_reg  <= 1'b0;
      taken_cnt_reg <= 16'h0000;
    end else begin
      br_valid_reg <= resolve;
      br_taken_reg <= resolve & cond_taken;
      if (resolve && cond_taken && taken_cnt_reg != 16'hFFFF) begin
        taken_cnt_reg <= taken_cnt_reg + 16'd1;
      end
      if (flush) begin
        op_reg      <= ALU_ADD;
        illegal_reg <= 1'b0;
        valid_reg   <= 1'b0;
        branch_reg  <= 1'b0;
      end else if (!stall) begin
        op_reg      <= dec_op;
        illegal_reg <= dec_illegal;
        valid_reg   <= in_valid;
        branch_reg  <= dec_branch;
        funct3_reg  <= funct3;
      end
    end
  end

  assign ALUOp     = op_reg;
  assign out_valid = valid_reg;
  assign illegal   = illegal_reg;
  assign br_valid  = br_valid_reg;
  assign br_taken  = br_taken_reg;
  assign taken_cnt = taken_cnt_reg;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Bench for alu_ctrl_pipe: a directed vector table, a counter saturation
// sequence, then random traffic checked against a behavioural model.
module tb_alu_ctrl_pipe;

  logic        clk = 1'b0;
  logic        reset, in_valid, funct7_b30, stall, flush, zero, Less;
  logic [1:0]  main_op;
  logic [2:0]  funct3;
  logic [3:0]  ALUOp;
  logic        out_valid, illegal, br_valid, br_taken;
  logic [15:0] taken_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  alu_ctrl_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .main_op(main_op),
    .funct3(funct3), .funct7_b30(funct7_b30), .stall(stall), .flush(flush),
    .zero(zero), .Less(Less), .ALUOp(ALUOp), .out_valid(out_valid),
    .illegal(illegal), .br_valid(br_valid), .br_taken(br_taken),
    .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, iv; logic [1:0] mo; logic [2:0] f3; logic b30, st, fl, z, l;
    logic [3:0] e_op; logic e_v, e_ill, e_bv, e_bt; logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  // Model of what the stage currently holds
  typedef struct {
    logic v; logic [3:0] alu; logic ill; logic br; logic [2:0] f3;
  } held_t;

  held_t       m_held;
  logic        m_bv, m_bt;
  logic [15:0] m_cnt;

  task automatic add(input logic rst, iv, input logic [1:0] mo, input logic [2:0] f3,
                     input logic b30, st, fl, z, l, input logic [3:0] e_op,
                     input logic e_v, e_ill, e_bv, e_bt, input logic [15:0] e_cnt);
    vec_t t;
    t = '{rst, iv, mo, f3, b30, st, fl, z, l, e_op, e_v, e_ill, e_bv, e_bt, e_cnt};
    vecs.push_back(t);
  endtask

  task automatic drive(input logic rst, iv, input logic [1:0] mo, input logic [2:0] f3,
                       input logic b30, st, fl, z, l);
    reset = rst; in_valid = iv; main_op = mo; funct3 = f3;
    funct7_b30 = b30; stall = st; flush = fl; zero = z; Less = l;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Instruction semantics straight from the ALU control rules
  function automatic held_t decode(input logic iv, input logic [1:0] mo,
                                   input logic [2:0] f3, input logic b30);
    held_t h;
    h = '{iv, 4'd2, 1'b0, 1'b0, f3};
    if (mo == 2'd0) h.alu = 4'd2;
    else if (mo == 2'd1) begin
      if (f3 inside {3'd0, 3'd1, 3'd4, 3'd5}) begin h.alu = 4'd6; h.br = 1'b1; end
      else h.ill = 1'b1;
    end else if (mo == 2'd2) begin
      if (f3 == 3'd0) h.alu = b30 ? 4'd6 : 4'd2;
      else if (f3 == 3'd7) h.alu = 4'd0;
      else if (f3 == 3'd6) h.alu = 4'd1;
      else h.ill = 1'b1;
    end else h.ill = 1'b1;
    return h;
  endfunction

  function automatic logic outcome(input logic [2:0] f3, input logic z, input logic l);
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    if (f3 == 3'd4) return l;
    if (f3 == 3'd5) return !l;
    return 1'b0;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    logic res;
    if (reset) begin
      m_held = '{1'b0, 4'd2, 1'b0, 1'b0, 3'd0};
      m_bv = 0; m_bt = 0; m_cnt = 0;
    end else begin
      res  = m_held.v && m_held.br && !stall && !flush;
      m_bv = res;
      m_bt = res && outcome(m_held.f3, zero, Less);
      if (m_bt && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (flush) begin
        m_held.v = 0; m_held.ill = 0; m_held.br = 0; m_held.alu = 4'd2;
      end else if (!stall) begin
        m_held = decode(in_valid, main_op, funct3, funct7_b30);
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    //   rst iv mo f3 b30 st fl z l   op v ill bv bt cnt
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0);  // reset
    add(0, 1, 2, 0, 1, 0, 0, 0, 0,   6, 1, 0, 0, 0, 0);  // R SUB
    add(0, 1, 2, 7, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);  // R AND
    add(0, 1, 2, 6, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0);  // R OR
    add(0, 1, 2, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0, 0);  // R ADD
    add(0, 1, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0, 0);  // load/store
    add(0, 1, 1, 0, 0, 0, 0, 0, 0,   6, 1, 0, 0, 0, 0);  // BEQ enters
    add(0, 0, 0, 0, 0, 0, 0, 1, 0,   2, 0, 0, 1, 1, 1);  // BEQ taken
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 1);  // idle
    add(0, 1, 1, 4, 0, 0, 0, 0, 0,   6, 1, 0, 0, 0, 1);  // BLT enters
    add(0, 0, 0, 0, 0, 1, 0, 0, 1,   6, 1, 0, 0, 0, 1);  // stall 1
    add(0, 0, 0, 0, 0, 1, 0, 0, 1,   6, 1, 0, 0, 0, 1);  // stall 2
    add(0, 0, 0, 0, 0, 1, 0, 0, 1,   6, 1, 0, 0, 0, 1);  // stall 3
    add(0, 0, 0, 0, 0, 0, 0, 0, 1,   2, 0, 0, 1, 1, 2);  // BLT resolves once
    add(0, 0, 0, 0, 0, 0, 0, 0, 1,   2, 0, 0, 0, 0, 2);  // no second pulse
    add(0, 1, 1, 1, 0, 0, 0, 0, 0,   6, 1, 0, 0, 0, 2);  // BNE enters
    add(0, 0, 0, 0, 0, 0, 0, 1, 0,   2, 0, 0, 1, 0, 2);  // BNE not taken
    add(0, 1, 1, 5, 0, 0, 0, 0, 0,   6, 1, 0, 0, 0, 2);  // BGE enters
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 1, 1, 3);  // BGE taken
    add(0, 1, 2, 0, 1, 0, 0, 0, 0,   6, 1, 0, 0, 0, 3);  // R SUB loaded
    add(0, 1, 2, 7, 0, 1, 1, 0, 0,   2, 0, 0, 0, 0, 3);  // flush+stall
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 3);  // after flush
    add(0, 1, 1, 0, 0, 0, 0, 0, 0,   6, 1, 0, 0, 0, 3);  // BEQ enters
    add(0, 0, 0, 0, 0, 0, 1, 1, 0,   2, 0, 0, 0, 0, 3);  // flushed at resolve
    add(0, 0, 0, 0, 0, 0, 0, 1, 0,   2, 0, 0, 0, 0, 3);  // stays dead
    add(0, 1, 3, 0, 0, 0, 0, 0, 0,   2, 1, 1, 0, 0, 3);  // main_op 11
    add(0, 1, 1, 2, 0, 0, 0, 0, 0,   2, 1, 1, 0, 0, 3);  // branch f3=010
    add(0, 0, 0, 0, 0, 0, 0, 1, 0,   2, 0, 0, 0, 0, 3);  // illegal branch no resolve
    add(0, 1, 2, 1, 0, 0, 0, 0, 0,   2, 1, 1, 0, 0, 3);  // R f3=001
    add(0, 1, 1, 0, 0, 0, 0, 0, 0,   6, 1, 0, 0, 0, 3);  // BEQ enters
    add(1, 0, 0, 0, 0, 1, 1, 1, 0,   2, 0, 0, 0, 0, 0);  // reset beats pending branch
    add(0, 0, 0, 0, 0, 0, 0, 1, 0,   2, 0, 0, 0, 0, 0);  // never resolves

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].mo, vecs[i].f3, vecs[i].b30,
            vecs[i].st, vecs[i].fl, vecs[i].z, vecs[i].l);
      step();
      $display("vec %0d: op=%b v=%b ill=%b bv=%b bt=%b cnt=%0d", i, ALUOp,
               out_valid, illegal, br_valid, br_taken, taken_cnt);
      check($sformatf("vec%0d.ALUOp", i), ALUOp, vecs[i].e_op);
      check($sformatf("vec%0d.out_valid", i), out_valid, vecs[i].e_v);
      check($sformatf("vec%0d.illegal", i), illegal, vecs[i].e_ill);
      check($sformatf("vec%0d.br_valid", i), br_valid, vecs[i].e_bv);
      check($sformatf("vec%0d.br_taken", i), br_taken, vecs[i].e_bt);
      check($sformatf("vec%0d.taken_cnt", i), taken_cnt, vecs[i].e_cnt);
    end

    // Saturation: back-to-back taken BEQs; after k edges, k-1 have resolved
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 1, 1, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 65538; k++) begin
      step();
      if (k == 65535) check("sat.cnt_65534", taken_cnt, 32'hFFFE);
      if (k == 65536) check("sat.cnt_ffff", taken_cnt, 32'hFFFF);
    end
    $display("sat: cnt=%0h bv=%b bt=%b", taken_cnt, br_valid, br_taken);
    check("sat.hold_ffff", taken_cnt, 32'hFFFF);
    check("sat.still_pulsing", {br_valid, br_taken}, 2'b11);
    drive(1, 1, 1, 0, 0, 0, 0, 1, 0);
    step();
    $display("sat reset: op=%b v=%b ill=%b bv=%b bt=%b cnt=%0d", ALUOp,
             out_valid, illegal, br_valid, br_taken, taken_cnt);
    check("satrst.outs", {ALUOp, out_valid, illegal, br_valid, br_taken, taken_cnt},
          {4'd2, 4'b0000, 16'd0});
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    check("satrst.no_pulse", {br_valid, taken_cnt}, 17'd0);

    // Random traffic against the model
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    model_edge();
    step();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            1'($urandom), 1'($urandom));
      model_edge();
      step();
      check($sformatf("rand%0d", c),
            {ALUOp, out_valid, illegal, br_valid, br_taken, taken_cnt},
            {m_held.alu, m_held.v, m_held.ill, m_bv, m_bt, m_cnt});
    end
    $display("random: %0d cycles done, model cnt=%0d", 3000, m_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
